// File: rtl/forward_stall_unit.sv
// Operand forwarding, WB-to-ID bypass and stall generation for an in-order
// pipeline. It also tracks a single outstanding multi-cycle mul/div operation.
module forward_stall_unit #(
  parameter int ADDR_W   = 5,
  parameter int MD_LAT   = 32,
  parameter int ZERO_FWD = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ID_RS1,
  input  logic [ADDR_W-1:0] ID_RS2,
  input  logic              ID_USE1,
  input  logic              ID_USE2,
  input  logic              ID_MD,
  input  logic [ADDR_W-1:0] EX_RD,
  input  logic [ADDR_W-1:0] MEM_RD,
  input  logic [ADDR_W-1:0] WB_RD,
  input  logic              EX_WE,
  input  logic              MEM_WE,
  input  logic              WB_WE,
  input  logic              EX_LOAD,
  input  logic              MD_START,
  input  logic [ADDR_W-1:0] MD_RD,
  output logic [1:0]        FWD1_SEL,
  output logic [1:0]        FWD2_SEL,
  output logic              ID1_BYP,
  output logic              ID2_BYP,
  output logic              STALL,
  output logic              MD_BUSY,
  output logic              MD_DONE,
  output logic              MD_OVERRUN
);

  localparam int CNT_W = $clog2(MD_LAT + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic              md_done_q, md_done_d;
  logic              overrun_q, overrun_d;
  logic [1:0]        fwd1_q, fwd1_d;
  logic [1:0]        fwd2_q, fwd2_d;
  logic              load_haz, md_haz;

  // Register 0 is hard-wired to zero unless ZERO_FWD asks for it to match.
  function automatic logic match(input logic [ADDR_W-1:0] a,
                                 input logic [ADDR_W-1:0] b);
    return (a == b) && ((ZERO_FWD != 0) || (a != '0));
  endfunction

  // The EX producer is newer than the MEM producer, so it wins. A load in EX
  // has no data yet; that case is handled by the stall.
  function automatic logic [1:0] fwd_sel(input logic use_rs,
                                         input logic [ADDR_W-1:0] rs);
    if (use_rs && EX_WE && !EX_LOAD && match(EX_RD, rs))
      return 2'b10;
    else if (use_rs && MEM_WE && match(MEM_RD, rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Combinational bypass and hazard detection
  always_comb begin
    ID1_BYP  = WB_WE && match(WB_RD, ID_RS1);
    ID2_BYP  = WB_WE && match(WB_RD, ID_RS2);
    MD_BUSY  = (cnt_q != '0);
    load_haz = EX_LOAD && EX_WE &&
               ((ID_USE1 && match(EX_RD, ID_RS1)) ||
                (ID_USE2 && match(EX_RD, ID_RS2)));
    md_haz   = (MD_BUSY || md_done_q) &&
               (ID_MD || (ID_USE1 && match(pend_rd_q, ID_RS1)) ||
                         (ID_USE2 && match(pend_rd_q, ID_RS2)));
    STALL    = load_haz || md_haz;
  end

  // Next-state for the forwarding selects and the mul/div tracker
  always_comb begin
    fwd1_d    = 2'b00;
    fwd2_d    = 2'b00;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    md_done_d = (cnt_q == CNT_W'(1));
    overrun_d = overrun_q;
    // A stalled edge injects a bubble into EX, which must not forward.
    if (!STALL) begin
      fwd1_d = fwd_sel(ID_USE1, ID_RS1);
      fwd2_d = fwd_sel(ID_USE2, ID_RS2);
    end
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (MD_START)
        overrun_d = 1'b1;
    end else if (MD_START) begin
      // Also taken in the done cycle, which replaces the old destination.
      cnt_d     = CNT_W'(MD_LAT);
      pend_rd_d = MD_RD;
    end else if (md_done_q) begin
      pend_rd_d = '0;
    end
  end

  // State registers; reset aborts any outstanding mul/div
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fwd1_q    <= 2'b00;
      fwd2_q    <= 2'b00;
      cnt_q     <= '0;
      pend_rd_q <= '0;
      md_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fwd1_q    <= fwd1_d;
      fwd2_q    <= fwd2_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
      md_done_q <= md_done_d;
      overrun_q <= overrun_d;
    end
  end

  assign FWD1_SEL   = fwd1_q;
  assign FWD2_SEL   = fwd2_q;
  assign MD_DONE    = md_done_q;
  assign MD_OVERRUN = overrun_q;

endmodule

// File: tb/tb_forward_stall_unit.sv
// Directed bench for forward_stall_unit: two instances share all inputs and
// differ only in ZERO_FWD, both with a 4-cycle mul/div latency.
module tb_forward_stall_unit;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, md_rd;
  logic       id_use1, id_use2, id_md, ex_we, mem_we, wb_we, ex_load, md_start;

  logic [1:0] fwd1_sel, fwd2_sel;
  logic       id1_byp, id2_byp, stall, md_busy, md_done, md_overrun;
  logic [1:0] z_fwd1_sel, z_fwd2_sel;
  logic       z_id1_byp, z_id2_byp, z_stall, z_md_busy, z_md_done, z_md_overrun;

  int total = 0;
  int bad   = 0;

  forward_stall_unit #(.ADDR_W(5), .MD_LAT(4), .ZERO_FWD(0)) dut (
    .CLK(clk), .RESET(rst),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USE1(id_use1), .ID_USE2(id_use2),
    .ID_MD(id_md), .EX_RD(ex_rd), .MEM_RD(mem_rd), .WB_RD(wb_rd),
    .EX_WE(ex_we), .MEM_WE(mem_we), .WB_WE(wb_we), .EX_LOAD(ex_load),
    .MD_START(md_start), .MD_RD(md_rd),
    .FWD1_SEL(fwd1_sel), .FWD2_SEL(fwd2_sel), .ID1_BYP(id1_byp),
    .ID2_BYP(id2_byp), .STALL(stall), .MD_BUSY(md_busy), .MD_DONE(md_done),
    .MD_OVERRUN(md_overrun)
  );

  forward_stall_unit #(.ADDR_W(5), .MD_LAT(4), .ZERO_FWD(1)) dut_z (
    .CLK(clk), .RESET(rst),
    .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USE1(id_use1), .ID_USE2(id_use2),
    .ID_MD(id_md), .EX_RD(ex_rd), .MEM_RD(mem_rd), .WB_RD(wb_rd),
    .EX_WE(ex_we), .MEM_WE(mem_we), .WB_WE(wb_we), .EX_LOAD(ex_load),
    .MD_START(md_start), .MD_RD(md_rd),
    .FWD1_SEL(z_fwd1_sel), .FWD2_SEL(z_fwd2_sel), .ID1_BYP(z_id1_byp),
    .ID2_BYP(z_id2_byp), .STALL(z_stall), .MD_BUSY(z_md_busy),
    .MD_DONE(z_md_done), .MD_OVERRUN(z_md_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    md_rd = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0; id_md = 1'b0;
    ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0; ex_load = 1'b0; md_start = 1'b0;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    #2;
    chk2("rst_fwd1", fwd1_sel, 2'b00);
    chk2("rst_fwd2", fwd2_sel, 2'b00);
    chk1("rst_busy", md_busy, 1'b0);
    chk1("rst_done", md_done, 1'b0);
    chk1("rst_ovr", md_overrun, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // EX and MEM both produce r5: EX wins
    ex_rd = 5'd5; ex_we = 1'b1; id_rs1 = 5'd5; id_use1 = 1'b1;
    mem_rd = 5'd5; mem_we = 1'b1;
    #1;
    chk1("exmem_stall", stall, 1'b0);
    tick();
    chk2("exmem_fwd1", fwd1_sel, 2'b10);
    chk2("exmem_fwd2", fwd2_sel, 2'b00);

    // Only MEM produces r5
    ex_we = 1'b0; id_rs2 = 5'd5; id_use2 = 1'b1;
    tick();
    chk2("mem_fwd1", fwd1_sel, 2'b01);
    chk2("mem_fwd2", fwd2_sel, 2'b01);

    // WB bypass to ID
    wb_we = 1'b1; wb_rd = 5'd3; id_rs1 = 5'd3;
    #1;
    chk1("byp1", id1_byp, 1'b1);
    chk1("byp2", id2_byp, 1'b0);

    // Load-use on rs2: stall, bubble carries no forwarding
    clear_in();
    ex_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use2 = 1'b1;
    mem_rd = 5'd7; mem_we = 1'b1;
    #1;
    chk1("lu_stall", stall, 1'b1);
    tick();
    chk2("lu_fwd2_bubble", fwd2_sel, 2'b00);
    ex_load = 1'b0; ex_we = 1'b0;
    #1;
    chk1("lu_stall_gone", stall, 1'b0);
    tick();
    chk2("lu_fwd2_mem", fwd2_sel, 2'b01);
    ex_load = 1'b1; ex_we = 1'b1; id_use2 = 1'b0;
    #1;
    chk1("lu_nouse_stall", stall, 1'b0);

    // Mul/div to r9 with a dependent consumer in ID
    clear_in();
    md_start = 1'b1; md_rd = 5'd9;
    tick();
    md_start = 1'b0; id_rs1 = 5'd9; id_use1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1($sformatf("md_stall_%0d", i), stall, 1'b1);
      chk1($sformatf("md_busy_%0d", i), md_busy, (i < 4) ? 1'b1 : 1'b0);
      chk1($sformatf("md_done_%0d", i), md_done, (i == 4) ? 1'b1 : 1'b0);
      tick();
    end
    chk1("md_after_stall", stall, 1'b0);
    chk1("md_after_busy", md_busy, 1'b0);
    chk1("md_after_done", md_done, 1'b0);
    chk1("md_no_ovr", md_overrun, 1'b0);

    // Overrun: second start while CNT=2 is ignored
    clear_in();
    md_start = 1'b1; md_rd = 5'd12;
    tick();
    md_start = 1'b0;
    tick();
    tick();
    md_start = 1'b1; md_rd = 5'd20;
    tick();
    md_start = 1'b0;
    chk1("ovr_set", md_overrun, 1'b1);
    chk1("ovr_busy", md_busy, 1'b1);
    id_rs1 = 5'd20; id_use1 = 1'b1;
    #1;
    chk1("ovr_pend_not20", stall, 1'b0);
    id_rs1 = 5'd12;
    #1;
    chk1("ovr_pend_12", stall, 1'b1);
    tick();
    chk1("ovr_done_sched", md_done, 1'b1);
    chk1("ovr_busy_off", md_busy, 1'b0);
    // Start accepted in the done cycle
    md_start = 1'b1; md_rd = 5'd3;
    tick();
    md_start = 1'b0;
    chk1("dstart_busy", md_busy, 1'b1);
    chk1("dstart_done", md_done, 1'b0);
    id_rs1 = 5'd3;
    #1;
    chk1("dstart_pend3", stall, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk1("dstart_done2", md_done, 1'b1);
    tick();
    chk1("dstart_done_clr", md_done, 1'b0);
    chk1("dstart_stall_clr", stall, 1'b0);
    chk1("ovr_sticky", md_overrun, 1'b1);

    // All addresses zero, all enables on
    clear_in();
    ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1; id_use1 = 1'b1; id_use2 = 1'b1;
    #1;
    chk1("z0_byp1", id1_byp, 1'b0);
    chk1("z0_stall", stall, 1'b0);
    chk1("z1_byp1", z_id1_byp, 1'b1);
    tick();
    chk2("z0_fwd1", fwd1_sel, 2'b00);
    chk2("z0_fwd2", fwd2_sel, 2'b00);
    chk2("z1_fwd1", z_fwd1_sel, 2'b10);

    // Reset mid-operation aborts it
    clear_in();
    md_start = 1'b1; md_rd = 5'd4;
    ex_we = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6; id_use1 = 1'b1;
    tick();
    md_start = 1'b0;
    tick();
    chk2("pre_rst_fwd1", fwd1_sel, 2'b10);
    id_use1 = 1'b0; id_md = 1'b1;
    #1;
    chk1("idmd_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    chk1("arst_busy", md_busy, 1'b0);
    chk2("arst_fwd1", fwd1_sel, 2'b00);
    chk1("arst_ovr", md_overrun, 1'b0);
    chk1("arst_stall", stall, 1'b0);
    tick();
    rst = 1'b0;
    clear_in();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1($sformatf("arst_nodone_%0d", i), md_done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
